// File: rtl/ibex_multdiv_pkg.sv
// Shared operator/state types and width-agnostic sign helpers for the
// iterative multiply/divide unit.
package ibex_multdiv_pkg;

    // Widest datapath the helpers serve; callers truncate to their own width.
    localparam int unsigned MD_MAX_W = 128;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_MULH = 2'd1,
        MD_DIV  = 2'd2,
        MD_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL      = 3'd1,
        ST_DIV_PREP = 3'd2,
        ST_DIV      = 3'd3,
        ST_DIV_FIX  = 3'd4,
        ST_DONE     = 3'd5
    } md_state_e;

    // Low N bits of the result are the N-bit two's complement negation of
    // the low N bits of v, so one function serves every width.
    function automatic logic [MD_MAX_W-1:0] md_negate(input logic [MD_MAX_W-1:0] v);
        return ~v + MD_MAX_W'(1);
    endfunction

    function automatic logic [MD_MAX_W-1:0] md_abs(input logic [MD_MAX_W-1:0] v,
                                                   input logic              neg);
        return neg ? md_negate(v) : v;
    endfunction

endpackage

// File: rtl/ibex_div_step.sv
// One restoring radix-2 division step: shift in the next numerator bit and
// subtract the divisor when it fits.
module ibex_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] den,
    input  logic             num_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {rem, num_bit};
        diff     = shifted - {1'b0, den};
        // With rem < den the difference stays below 2^WIDTH when it fits,
        // so its top bit is exactly the borrow.
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit with valid/ready handshakes.
// Optional IBEX_MULTDIV_DIT_EN adds data_ind_timing_i (fixed divide latency).
module ibex_multdiv_iter
    import ibex_multdiv_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_CHUNK = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
`ifdef IBEX_MULTDIV_DIT_EN
    input  logic             data_ind_timing_i,
`endif
    input  logic             kill_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned N_MUL  = WIDTH / MUL_CHUNK;
    localparam int unsigned ACC_W  = 2 * WIDTH + 2;
    localparam int unsigned PROD_W = WIDTH + MUL_CHUNK + 2;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

    md_state_e        state_q;
    md_op_e           op_q;
    logic [1:0]       sm_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] num_q;
    logic [WIDTH-1:0] den_q;
    logic [WIDTH-1:0] rem_q;
    logic             div_zero_q;

    logic             sign_a;
    logic             sign_b;
    logic             b_zero;
    logic             short_zero;
    logic             last_chunk;
    logic             last_step;
    logic signed [WIDTH:0]       a_ext;
    logic signed [MUL_CHUNK:0]   chunk_ext;
    logic signed [PROD_W-1:0]    prod;
    logic [ACC_W-1:0] acc_nxt;
    logic [WIDTH-1:0] zero_res;
    logic [WIDTH-1:0] div_res;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;

    assign sign_a     = sm_q[0] & a_q[WIDTH-1];
    assign sign_b     = sm_q[1] & b_q[WIDTH-1];
    assign b_zero     = (b_q == '0);
    assign last_chunk = (cnt_q == CNT_W'(N_MUL - 1));
    assign last_step  = (cnt_q == CNT_W'(WIDTH - 1));
    assign zero_res   = (op_q == MD_DIV) ? '1 : a_q;

`ifdef IBEX_MULTDIV_DIT_EN
    logic dit_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dit_q <= 1'b0;
        end else if (state_q == ST_IDLE && req_valid_i) begin
            dit_q <= data_ind_timing_i;
        end
    end

    assign short_zero = b_zero & ~dit_q;
`else
    assign short_zero = b_zero;
`endif

    // Multiply datapath: signed (WIDTH+1) x (MUL_CHUNK+1) partial product,
    // only the top chunk of op_b may carry a sign.
    // NOTE: every variable written here gets a value on every path, so no latch.
    always_comb begin
        a_ext     = {sign_a, a_q};
        chunk_ext = {last_chunk & sm_q[1] & b_sh_q[MUL_CHUNK-1], b_sh_q[MUL_CHUNK-1:0]};
        prod      = PROD_W'(a_ext) * PROD_W'(chunk_ext);
        acc_nxt   = acc_q + (ACC_W'(prod) << (32'(cnt_q) * MUL_CHUNK));
    end

    ibex_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem      (rem_q),
        .den      (den_q),
        .num_bit  (num_q[WIDTH-1]),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    // Sign fix-up; a zero divisor that ran the full iteration still returns
    // the architectural all-ones / dividend.
    always_comb begin
        if (div_zero_q) begin
            div_res = zero_res;
        end else if (op_q == MD_DIV) begin
            div_res = (sign_a ^ sign_b) ? WIDTH'(md_negate(MD_MAX_W'(num_q))) : num_q;
        end else begin
            div_res = sign_a ? WIDTH'(md_negate(MD_MAX_W'(rem_q))) : rem_q;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign req_ready_o = (state_q == ST_IDLE);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            res_valid_o <= 1'b0;
            result_o    <= '0;
            op_q        <= MD_MUL;
            sm_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            num_q       <= '0;
            den_q       <= '0;
            rem_q       <= '0;
            div_zero_q  <= 1'b0;
        end else if (kill_i && state_q != ST_IDLE) begin
            state_q     <= ST_IDLE;
            res_valid_o <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_q    <= md_op_e'(operator_i);
                        sm_q    <= signed_mode_i;
                        a_q     <= op_a_i;
                        b_q     <= op_b_i;
                        b_sh_q  <= op_b_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= operator_i[1] ? ST_DIV_PREP : ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_q  <= acc_nxt;
                    b_sh_q <= b_sh_q >> MUL_CHUNK;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_chunk) begin
                        state_q     <= ST_DONE;
                        res_valid_o <= 1'b1;
                        result_o    <= (op_q == MD_MULH) ? acc_nxt[2*WIDTH-1:WIDTH]
                                                         : acc_nxt[WIDTH-1:0];
                    end
                end
                ST_DIV_PREP: begin
                    num_q      <= WIDTH'(md_abs(MD_MAX_W'(a_q), sign_a));
                    den_q      <= WIDTH'(md_abs(MD_MAX_W'(b_q), sign_b));
                    rem_q      <= '0;
                    cnt_q      <= '0;
                    div_zero_q <= b_zero;
                    if (short_zero) begin
                        state_q     <= ST_DONE;
                        res_valid_o <= 1'b1;
                        result_o    <= zero_res;
                    end else begin
                        state_q <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_nxt;
                    num_q <= {num_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        state_q <= ST_DIV_FIX;
                    end
                end
                ST_DIV_FIX: begin
                    state_q     <= ST_DONE;
                    res_valid_o <= 1'b1;
                    result_o    <= div_res;
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        state_q     <= ST_IDLE;
                        res_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    res_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench for ibex_multdiv_iter: a 32-bit instance and a
// 16-bit / 4-bit-chunk instance, with a scoreboard of expected results.
module tb_ibex_multdiv_iter;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid_s = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [1:0]  sm = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        kill = 1'b0;
    logic        res_ready = 1'b0;
    logic        req_ready;
    logic        res_valid;
    logic [31:0] result;
    logic        busy;
    logic        req_ready_s;
    logic        res_valid_s;
    logic [15:0] result_s;
    logic        busy_s;
`ifdef IBEX_MULTDIV_DIT_EN
    logic        dit = 1'b0;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t sb16[$];

    always #5 clk = ~clk;

    ibex_multdiv_iter #(
        .WIDTH(32),
        .MUL_CHUNK(16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .operator_i    (op),
        .signed_mode_i (sm),
        .op_a_i        (a),
        .op_b_i        (b),
`ifdef IBEX_MULTDIV_DIT_EN
        .data_ind_timing_i(dit),
`endif
        .kill_i        (kill),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .result_o      (result),
        .busy_o        (busy)
    );

    ibex_multdiv_iter #(
        .WIDTH(16),
        .MUL_CHUNK(4)
    ) dut16 (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid_s),
        .req_ready_o   (req_ready_s),
        .operator_i    (op),
        .signed_mode_i (sm),
        .op_a_i        (a[15:0]),
        .op_b_i        (b[15:0]),
`ifdef IBEX_MULTDIV_DIT_EN
        .data_ind_timing_i(1'b0),
`endif
        .kill_i        (kill),
        .res_valid_o   (res_valid_s),
        .res_ready_i   (res_ready),
        .result_o      (result_s),
        .busy_o        (busy_s)
    );

    // Reference: 64-bit arithmetic with per-operand signedness, truncating division.
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [1:0] s,
                                              input logic [31:0] x, input logic [31:0] y);
        longint ax;
        longint bx;
        longint p;
        longint q;
        longint r;
        ax = s[0] ? longint'($signed(x)) : longint'({32'h0, x});
        bx = s[1] ? longint'($signed(y)) : longint'({32'h0, y});
        p  = ax * bx;
        if (o == 2'd0) return p[31:0];
        if (o == 2'd1) return p[63:32];
        if (y == 32'h0) return (o == 2'd2) ? 32'hFFFF_FFFF : x;
        q = ax / bx;
        r = ax % bx;
        return (o == 2'd2) ? q[31:0] : r[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] y);
        if (!o[1]) return 3;
        return (y == 32'h0) ? 2 : 35;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic start_op(input logic [1:0] o, input logic [1:0] s, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat,
                            input string nm, input bit track);
        exp_t e;
        op = o; sm = s; a = x; b = y; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: req_ready=%b want 1", nm, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (track) begin
            e.res = exp_res; e.lat = exp_lat; e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic wait_result();
        exp_t e;
        int   lat = 1;
        while (res_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard: result with no expectation");
            return;
        end
        e = sb.pop_front();
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout: res_valid=%b want 1", e.name, res_valid);
            return;
        end
        checks++;
        if (result !== e.res) begin
            failures++;
            $display("FAIL %s result: got %h want %h", e.name, result, e.res);
        end
        checks++;
        if (lat != e.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat);
        end
    endtask

    task automatic drain();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drain: valid=%b ready=%b busy=%b want 0 1 0", res_valid, req_ready, busy);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [1:0] s, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat,
                          input string nm);
        start_op(o, s, x, y, exp_res, exp_lat, nm, 1'b1);
        wait_result();
        drain();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset32: ready=%b valid=%b result=%h busy=%b want 1 0 0 0",
                     req_ready, res_valid, result, busy);
        end
        checks++;
        if (req_ready_s !== 1'b1 || res_valid_s !== 1'b0 || result_s !== 16'h0 || busy_s !== 1'b0) begin
            failures++;
            $display("FAIL reset16: ready=%b valid=%b result=%h busy=%b want 1 0 0 0",
                     req_ready_s, res_valid_s, result_s, busy_s);
        end
    endtask

    task automatic test_mul();
        run_op(2'd0, 2'b11, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3, "mul_7xm3");
        run_op(2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3, "mulh_min");
        run_op(2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, "mulhu_max");
        run_op(2'd1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, "mulhsu_m1");
        run_op(2'd1, 2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, "mulh_10");
    endtask

    task automatic test_mul_w16();
        logic [15:0] xs [2] = '{16'hFFFF, 16'hFFFF};
        logic [15:0] ys [2] = '{16'hFFFF, 16'h0003};
        logic [1:0]  os [2] = '{2'd1, 2'd0};
        logic [1:0]  ss [2] = '{2'b00, 2'b11};
        logic [15:0] rs [2] = '{16'hFFFE, 16'hFFFD};
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            int   lat = 1;
            op = os[i]; sm = ss[i]; a = {16'h0, xs[i]}; b = {16'h0, ys[i]};
            req_valid_s = 1'b1;
            e.res = {16'h0, rs[i]}; e.lat = 5; e.name = (i == 0) ? "w16_mulhu" : "w16_mul";
            sb16.push_back(e);
            @(posedge clk); #1;
            req_valid_s = 1'b0;
            while (res_valid_s !== 1'b1 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            e = sb16.pop_front();
            checks++;
            if (res_valid_s !== 1'b1 || {16'h0, result_s} !== e.res) begin
                failures++;
                $display("FAIL %s result: valid=%b got %h want %h", e.name, res_valid_s, result_s, e.res[15:0]);
            end
            checks++;
            if (lat != e.lat) begin
                failures++;
                $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat);
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            checks++;
            if (res_valid_s !== 1'b0 || busy_s !== 1'b0) begin
                failures++;
                $display("FAIL %s drain: valid=%b busy=%b want 0 0", e.name, res_valid_s, busy_s);
            end
        end
    endtask

    task automatic test_div();
        run_op(2'd2, 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 35, "div_m7_2");
        run_op(2'd3, 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 35, "rem_m7_2");
        run_op(2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, "div_ovf");
        run_op(2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 35, "rem_ovf");
        run_op(2'd2, 2'b00, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 35, "divu_big");
        run_op(2'd3, 2'b00, 32'd100, 32'd7, 32'd2, 35, "remu_100_7");
    endtask

    task automatic test_div_zero();
        run_op(2'd2, 2'b11, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "div_by0");
        run_op(2'd3, 2'b11, 32'd5, 32'd0, 32'd5, 2, "rem_by0");
        run_op(2'd3, 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2, "rem_neg_by0");
`ifdef IBEX_MULTDIV_DIT_EN
        dit = 1'b1;
        run_op(2'd2, 2'b11, 32'd5, 32'd0, 32'hFFFF_FFFF, 35, "dit_div_by0");
        run_op(2'd3, 2'b11, 32'd5, 32'd0, 32'd5, 35, "dit_rem_by0");
        run_op(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 35, "dit_div_neg_by0");
        dit = 1'b0;
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_res;
        exp_res = ref_model(2'd0, 2'b00, 32'h0001_2345, 32'h0000_0100);
        start_op(2'd0, 2'b00, 32'h0001_2345, 32'h0000_0100, exp_res, 3, "bp_mul", 1'b1);
        wait_result();
        op = 2'd2; a = 32'h1; b = 32'h1; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || result !== exp_res || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: valid=%b result=%h ready=%b want 1 %h 0",
                         i, res_valid, result, req_ready, exp_res);
            end
        end
        req_valid = 1'b0;
        drain();
    endtask

    task automatic test_kill();
        bit seen = 1'b0;
        start_op(2'd2, 2'b11, 32'd100, 32'd7, 32'h0, 0, "kill_div", 1'b0);
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL kill_pre: busy=%b valid=%b want 1 0", busy, res_valid);
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL kill_idle: busy=%b ready=%b valid=%b want 0 1 0", busy, req_ready, res_valid);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL kill_no_result: res_valid rose after kill want stay 0");
        end
        // kill in IDLE is ignored and the concurrent request is accepted
        kill = 1'b1;
        start_op(2'd2, 2'b00, 32'd100, 32'd7, 32'd14, 35, "kill_in_idle", 1'b1);
        kill = 1'b0;
        wait_result();
        drain();
    endtask

    task automatic test_reset_mid();
        start_op(2'd0, 2'b00, 32'd3, 32'd5, 32'h0, 0, "rst_mul", 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: ready=%b valid=%b result=%h busy=%b want 1 0 0 0",
                     req_ready, res_valid, result, busy);
        end
        run_op(2'd0, 2'b00, 32'd3, 32'd5, 32'd15, 3, "after_rst");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  o;
            logic [1:0]  s;
            logic [31:0] x;
            logic [31:0] y;
            o = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'h0;
                1:       y = 32'($urandom_range(1, 20));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            run_op(o, s, x, y, ref_model(o, s, x, y), ref_lat(o, y), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_w16();
        test_div();
        test_div_zero();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
